pixel_stream_deserializer: RTL
==============================

Name: pixel_stream_deserializer

Overview:
- Receives the serial 1-bit pixel stream (data_in/valid_in, row-major, pixel 0 = top-left) and assembles a complete IMG_W x IMG_H binary frame in an internal single-buffered register array.
- Front end of the inference datapath: the classifier core reads the assembled frame row by row and releases the buffer with frame_ack.
- Counts and flags pixels that arrive while the buffer is still held.

Parameters:
- IMG_W, 28, pixels per row.
- IMG_H, 28, rows per frame; frame size N = IMG_W*IMG_H = 784.
- CNT_W, 10, pixel counter width; must satisfy 2^CNT_W > N.
- ROW_W, 5, row index width; must satisfy 2^ROW_W >= IMG_H.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- data_in  input  1  serial pixel value.
- valid_in  input  1  data_in is a valid pixel this cycle.
- frame_valid  output  1  complete frame held in buffer.
- frame_ack  input  1  consumer done; releases the buffer.
- rd_row  input  ROW_W  row index to read.
- rd_data  output  IMG_W  row contents; bit c = pixel (row, c).
- pixel_cnt  output  CNT_W  pixels accepted into the current frame.
- overflow  output  1  sticky: a pixel was dropped.
- drop_cnt  output  8  dropped-pixel count, saturating at 255.

Behaviour:
- Reset (async, rst_n=0):
  - State = FILL; frame_valid=0; pixel_cnt=0; overflow=0; drop_cnt=0; rd_data=0.
  - Buffer contents are not cleared. No test may depend on buffer contents after reset.
- States: FILL, FULL.
- FILL:
  - Each cycle with valid_in=1 writes data_in to buffer[pixel_cnt] (row = pixel_cnt / IMG_W, col = pixel_cnt % IMG_W) and increments pixel_cnt.
  - valid_in=0 cycles (gaps) have no effect.
  - When the accepted pixel has pixel_cnt == N-1, go to FULL. On that same edge: frame_valid=1 and pixel_cnt=N.
  - frame_valid therefore rises on the clock edge that samples the last pixel.
- FULL:
  - frame_valid holds at 1; the buffer is frozen.
  - valid_in=1 drops the pixel: overflow<=1; drop_cnt increments, saturating at 255.
  - frame_ack=1 moves to FILL on the next edge: frame_valid=0, pixel_cnt=0.
  - If valid_in=1 in the same cycle as frame_ack, that pixel is dropped and counted; the new frame starts with the following valid pixel.
- frame_ack while in FILL is ignored.
- overflow and drop_cnt clear only on reset.
- Read port:
  - rd_data is registered with 1-cycle latency: rd_row sampled at edge k gives that row's bits at edge k.
  - Valid in any state. Content is defined only while frame_valid=1.
  - rd_row >= IMG_H returns all zeros.
- No partial-frame timeout: a stalled stream keeps pixel_cnt at its current value indefinitely.
- Reset mid-frame discards the partial frame: pixel_cnt returns to 0 and the next valid pixel is pixel 0.
- No combinational path from any input to any output.

Test Plan:
- Frame load and readback:
  - Stimulus: reset, then 784 consecutive valid pixels of a known pattern (pixel i = 1 iff row==col).
  - Required: frame_valid rises at the edge of pixel 783; pixel_cnt=784.
  - Required: reading rows 0..27 returns one-hot rd_data = 1<<row, one cycle after each rd_row.
- Gapped stream:
  - Stimulus: same frame with valid_in=0 inserted every 3rd cycle.
  - Required: identical buffer contents; frame_valid rises only after the 784th valid pixel; pixel_cnt=783 immediately before that edge.
- Overflow:
  - Stimulus: after frame_valid, drive 5 valid pixels without ack; then frame_ack with valid_in=1 in the same cycle.
  - Required: drop_cnt=6; overflow=1; frame_valid=0 next cycle; pixel_cnt=0; frame contents unchanged until the ack.
- Back-to-back frames:
  - Stimulus: ack, then a second frame (all ones).
  - Required: row reads return 0x0FFFFFFF; overflow stays at its prior value.
- Reset mid-frame:
  - Stimulus: assert rst_n=0 asynchronously after 400 pixels, release, then send a full 784-pixel frame.
  - Required: outputs go to reset values immediately on assertion; frame_valid only after 784 new pixels.
  - Required: drop_cnt saturation checked separately with 300 dropped pixels gives 255.
- Out-of-range read:
  - Stimulus: rd_row=28 and rd_row=31 while frame_valid=1.
  - Required: rd_data=0 one cycle later.

Source files
------------

// File: rtl/pixel_stream_deserializer.sv
// pixel_stream_deserializer: assembles a serial 1-bit pixel stream into a single-buffered
// IMG_W x IMG_H binary frame and exposes it row by row through a registered read port.
module pixel_stream_deserializer #(
    parameter int IMG_W = 28,
    parameter int IMG_H = 28,
    parameter int CNT_W = 10,
    parameter int ROW_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             data_in,
    input  logic             valid_in,
    output logic             frame_valid,
    input  logic             frame_ack,
    input  logic [ROW_W-1:0] rd_row,
    output logic [IMG_W-1:0] rd_data,
    output logic [CNT_W-1:0] pixel_cnt,
    output logic             overflow,
    output logic [7:0]       drop_cnt
);
    localparam int COL_W = IMG_W > 1 ? $clog2(IMG_W) : 1;
    localparam logic [CNT_W-1:0] LAST_PIX = CNT_W'(IMG_W * IMG_H - 1);
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(IMG_W - 1);
    localparam logic [ROW_W:0] NUM_ROWS = (ROW_W + 1)'(IMG_H);

    typedef enum logic {FILL, FULL} state_t;

    state_t state, state_nxt;
    logic [ROW_W-1:0] row;
    logic [COL_W-1:0] col;
    logic [IMG_W-1:0] frame [IMG_H];
    logic accept, drop;

    assign accept = state == FILL && valid_in;
    assign drop   = state == FULL && valid_in;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= FILL;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state == FILL ? ((accept && pixel_cnt == LAST_PIX) ? FULL : FILL)
                                  : (frame_ack ? FILL : FULL);
    end

    always_comb begin
        frame_valid = state == FULL;
    end

    // row/col track pixel_cnt so the write address needs no divider
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pixel_cnt <= '0;
            row       <= '0;
            col       <= '0;
        end else if (accept) begin
            pixel_cnt <= pixel_cnt + 1'b1;
            col       <= col == LAST_COL ? '0 : col + 1'b1;
            row       <= col == LAST_COL ? row + 1'b1 : row;
        end else if (state == FULL && frame_ack) begin
            pixel_cnt <= '0;
            row       <= '0;
            col       <= '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else if (drop) begin
            overflow <= 1'b1;
            drop_cnt <= drop_cnt == 8'hff ? drop_cnt : drop_cnt + 1'b1;
        end
    end

    // frame storage is deliberately not reset
    always_ff @(posedge clk) begin
        if (accept) frame[row][col] <= data_in;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rd_data <= '0;
        else        rd_data <= {1'b0, rd_row} < NUM_ROWS ? frame[rd_row] : '0;
    end
endmodule
